// File: rtl/sad_pkg.sv
// Shared definitions for the stereo SAD engine: default pixel width,
// output width calculation and the pixel type.
package sad_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pixel_t;

  // Smallest width that holds win*win maximal absolute differences.
  function automatic int sad_width(input int win, input int pix_w);
    return $clog2(win * win * ((1 << pix_w) - 1) + 1);
  endfunction

endpackage

// File: rtl/sad_window_abs_diff.sv
// Combinational unsigned absolute difference of two pixels. The subtraction
// order is chosen by the comparison, so the result never wraps.
module abs_diff
  import sad_pkg::*;
#(
  parameter int PIX_W = sad_pkg::PIX_W
) (
  input  logic [PIX_W-1:0] a_i,
  input  logic [PIX_W-1:0] b_i,
  output logic [PIX_W-1:0] d_o
);

  assign d_o = (a_i >= b_i) ? (a_i - b_i) : (b_i - a_i);

endmodule

// File: rtl/sad_window.sv
// Two-stage sum-of-absolute-differences engine: per-pixel |a-b| registered
// in stage 1, summed into the SAD cost in stage 2. One window pair per clock.
module sad_window
  import sad_pkg::*;
#(
  parameter  int WIN   = 3,
  parameter  int PIX_W = sad_pkg::PIX_W,
  localparam int N     = WIN * WIN,
  localparam int SAD_W = sad_width(WIN, PIX_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [N*PIX_W-1:0] input_a,
  input  logic [N*PIX_W-1:0] input_b,
  output logic               out_valid,
  output logic [SAD_W-1:0]   sad
);

  logic [PIX_W-1:0] diff_p0   [N];
  logic [PIX_W-1:0] diff_p1_q [N];
  logic             vld_p1_q;
  logic [SAD_W-1:0] sum_d;
  logic [SAD_W-1:0] sad_q;
  logic             vld_p2_q;

  for (genvar g = 0; g < N; g++) begin : g_abs
    abs_diff #(.PIX_W(PIX_W)) u_abs (
      .a_i (input_a[PIX_W*g +: PIX_W]),
      .b_i (input_b[PIX_W*g +: PIX_W]),
      .d_o (diff_p0[g])
    );
  end

  // Stage 1: absolute differences; data loads every cycle, the flag gates use.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      diff_p1_q <= '{default: '0};
    end else begin
      vld_p1_q  <= in_valid;
      diff_p1_q <= diff_p0;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) begin
      sum_d = sum_d + SAD_W'(diff_p1_q[i]);
    end
  end

  // Stage 2: cost register holds across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2_q <= 1'b0;
      sad_q    <= '0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        sad_q <= sum_d;
      end
    end
  end

  assign out_valid = vld_p2_q;
  assign sad       = sad_q;

endmodule

// File: tb/tb_sad_window.sv
// Directed and random stimulus for sad_window with a queue-based scoreboard
// checking value, order and two-cycle latency.
module tb_sad_window;
  import sad_pkg::*;

  localparam int WIN   = 3;
  localparam int NPIX  = WIN * WIN;
  localparam int SAD_W = sad_width(WIN, 8);

  logic                clk;
  logic                rst_n;
  logic                in_valid;
  logic [NPIX*8-1:0]   input_a;
  logic [NPIX*8-1:0]   input_b;
  logic                out_valid;
  logic [SAD_W-1:0]    sad;

  int total;
  int bad;
  int sb[$];
  logic v_d1;
  int last_sad;

  sad_window #(.WIN(WIN), .PIX_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .input_a   (input_a),
    .input_b   (input_b),
    .out_valid (out_valid),
    .sad       (sad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int model(input logic [NPIX*8-1:0] a, input logic [NPIX*8-1:0] b);
    int s;
    int x;
    int y;
    s = 0;
    for (int i = 0; i < NPIX; i++) begin
      x = int'(a[8*i +: 8]);
      y = int'(b[8*i +: 8]);
      s += (x > y) ? (x - y) : (y - x);
    end
    return s;
  endfunction

  function automatic logic [NPIX*8-1:0] fill(input logic [7:0] p);
    logic [NPIX*8-1:0] r;
    for (int i = 0; i < NPIX; i++) r[8*i +: 8] = p;
    return r;
  endfunction

  function automatic logic [NPIX*8-1:0] rnd_win();
    logic [NPIX*8-1:0] r;
    for (int i = 0; i < NPIX; i++) r[8*i +: 8] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  // One clock: drive a pair (or bubble), push the expected cost, check outputs.
  task automatic step(input logic v, input logic [NPIX*8-1:0] a,
                      input logic [NPIX*8-1:0] b, input int exp_sad, input string tag);
    in_valid = v;
    input_a  = a;
    input_b  = b;
    if (v) sb.push_back(exp_sad);
    @(posedge clk);
    #1;
    chk({tag, "_vld"}, 32'(out_valid), 32'(v_d1));
    if (v_d1) begin
      if (sb.size() == 0) begin
        chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      end else begin
        last_sad = sb.pop_front();
        chk({tag, "_sad"}, 32'(sad), 32'(last_sad));
      end
    end else begin
      chk({tag, "_hold"}, 32'(sad), 32'(last_sad));
    end
    v_d1 = v;
  endtask

  initial begin
    logic [NPIX*8-1:0] ref_a;
    logic [NPIX*8-1:0] ref_b;
    logic [NPIX*8-1:0] ra;
    logic [NPIX*8-1:0] rb;
    logic rv;

    total = 0;
    bad = 0;
    v_d1 = 1'b0;
    last_sad = 0;
    ref_a = {8'd0, 8'd30, 8'd20, 8'd10, 8'd0, 8'd30, 8'd20, 8'd10, 8'd0};
    ref_b = {8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80, 8'd90, 8'd100, 8'd110};

    rst_n = 1'b0;
    in_valid = 1'b0;
    input_a = '0;
    input_b = '0;
    #12;
    chk("reset_vld", 32'(out_valid), 32'd0);
    chk("reset_sad", 32'(sad), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, '0, '0, 0, "idle");

    // Reference pulse, then bubbles holding the result.
    step(1'b1, ref_a, ref_b, 510, "ref");
    step(1'b0, rnd_win(), rnd_win(), 0, "ref_b1");
    step(1'b0, rnd_win(), rnd_win(), 0, "ref_b2");
    step(1'b0, rnd_win(), rnd_win(), 0, "ref_b3");

    step(1'b1, fill(8'd5), fill(8'd5), 0, "equal");
    step(1'b0, '0, '0, 0, "eq_b1");
    step(1'b0, '0, '0, 0, "eq_b2");
    step(1'b1, ref_b, ref_a, 510, "swap");
    step(1'b0, '0, '0, 0, "sw_b1");
    step(1'b0, '0, '0, 0, "sw_b2");
    step(1'b1, fill(8'd255), fill(8'd0), 2295, "max");
    step(1'b1, fill(8'd0), fill(8'd255), 2295, "max_rev");
    step(1'b0, '0, '0, 0, "mx_b1");
    step(1'b0, '0, '0, 0, "mx_b2");

    // Streaming three pairs back-to-back, then a bubble.
    step(1'b1, ref_a, ref_b, 510, "str_ref");
    step(1'b1, fill(8'd77), fill(8'd77), 0, "str_eq");
    step(1'b1, fill(8'd255), fill(8'd0), 2295, "str_max");
    step(1'b0, rnd_win(), rnd_win(), 0, "str_b1");
    step(1'b0, rnd_win(), rnd_win(), 0, "str_b2");
    step(1'b0, rnd_win(), rnd_win(), 0, "str_b3");

    // Mid-stream asynchronous reset flushes the in-flight pairs.
    step(1'b1, fill(8'd255), fill(8'd0), 2295, "pre_rst");
    step(1'b1, ref_a, ref_b, 510, "pre_rst2");
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst_async_vld", 32'(out_valid), 32'd0);
    chk("rst_async_sad", 32'(sad), 32'd0);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    v_d1 = 1'b0;
    last_sad = 0;
    step(1'b0, '0, '0, 0, "post_rst1");
    step(1'b0, '0, '0, 0, "post_rst2");
    step(1'b0, '0, '0, 0, "post_rst3");

    // Random pairs with random gaps against the behavioural model.
    for (int n = 0; n < 1000; n++) begin
      rv = ($urandom_range(0, 3) != 0);
      ra = rnd_win();
      rb = rnd_win();
      step(rv, ra, rb, model(ra, rb), "rand");
    end
    step(1'b0, '0, '0, 0, "drain1");
    step(1'b0, '0, '0, 0, "drain2");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
